// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: sequencer state type and table-word field layout.
// The optional care-mask field is enabled by defining VECTOR_CHECKER_MASK_EN.
package vector_checker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

`ifdef VECTOR_CHECKER_MASK_EN
   localparam int MASK_EN = 1;
`else
   localparam int MASK_EN = 0;
`endif

   // Word layout, MSB first: {inst, exp_pc, exp_acc[, mask]}
   function automatic int vec_width(input int inst_w, input int pc_w, input int acc_w);
      return inst_w + (1 + MASK_EN) * (pc_w + acc_w);
   endfunction

   function automatic int inst_lsb(input int pc_w, input int acc_w);
      return (1 + MASK_EN) * (pc_w + acc_w);
   endfunction

   function automatic int exp_lsb(input int pc_w, input int acc_w);
      return MASK_EN * (pc_w + acc_w);
   endfunction

   function automatic int mask_lsb();
      return 0;
   endfunction

endpackage

// File: rtl/vector_checker_mem.sv
// vector_checker_mem: vector table, one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module vector_checker_mem #(
   parameter int DEPTH = 24,
   parameter int WIDTH = 24,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Table write; addresses beyond the table are dropped
   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < (AW+1)'(DEPTH))) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/vector_checker.sv
// vector_checker: drives a processor from a vector table and checks its {pc,acc}.
// Define VECTOR_CHECKER_MASK_EN to add a per-bit care mask to every table word.
module vector_checker
   import vector_checker_pkg::*;
#(
   parameter int                INST_W   = 8,
   parameter int                PC_W     = 8,
   parameter int                ACC_W    = 8,
   parameter int                DEPTH    = 24,
   parameter int                EXP_LAT  = 0,
   parameter int                CNT_W    = 8,
   parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
   localparam int               AW       = $clog2(DEPTH),
   localparam int               VEC_W    = vec_width(INST_W, PC_W, ACC_W)
) (
   input  logic                  clk,
   input  logic                  CLB,
   input  logic                  ld_we,
   input  logic [AW-1:0]         ld_addr,
   input  logic [VEC_W-1:0]      ld_data,
   input  logic                  start,
   input  logic                  stop_on_err,
   input  logic [AW:0]           num_vec,
   output logic                  dut_clb,
   output logic [INST_W-1:0]     inst,
   input  logic [PC_W-1:0]       pc,
   input  logic [ACC_W-1:0]      acc,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      err_count,
   output logic [AW-1:0]         first_err_addr,
   output logic [PC_W+ACC_W-1:0] first_err_got
);

   localparam int PA_W     = PC_W + ACC_W;
   localparam int INST_LSB = inst_lsb(PC_W, ACC_W);
   localparam int EXP_LSB  = exp_lsb(PC_W, ACC_W);
   localparam int DW       = $clog2(EXP_LAT + 2);

   state_t            state_r;
   logic [AW-1:0]     addr_r;
   logic [AW-1:0]     last_r;
   logic              stop_r;
   logic [DW-1:0]     drain_r;

   logic              idle_s;
   logic              active_s;
   logic              mem_we_s;
   logic [AW:0]       nv_clamp_s;
   logic [VEC_W-1:0]  word_s;
   logic [PA_W-1:0]   exp_s;
   logic [PA_W-1:0]   mask_s;
   logic [PA_W-1:0]   got_s;
   logic              cmp_valid_s;
   logic [PA_W-1:0]   cmp_exp_s;
   logic [PA_W-1:0]   cmp_mask_s;
   logic [AW-1:0]     cmp_addr_s;
   logic              mism_s;
   logic [CNT_W-1:0]  err_next_s;
   logic              run_end_s;
   logic              drain_end_s;
   logic              to_done_s;

   assign idle_s   = (state_r == IDLE) || (state_r == DONE);
   assign active_s = (state_r == RUN) || (state_r == DRAIN);
   assign mem_we_s = ld_we && idle_s;

   vector_checker_mem #(
      .DEPTH (DEPTH),
      .WIDTH (VEC_W),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (addr_r),
      .rdata (word_s)
   );

   assign exp_s = word_s[EXP_LSB +: PA_W];
   assign got_s = {pc, acc};

`ifdef VECTOR_CHECKER_MASK_EN
   assign mask_s = word_s[mask_lsb() +: PA_W];
`else
   assign mask_s = {PA_W{1'b1}};
`endif

   generate
      if (EXP_LAT == 0) begin : g_direct
         assign cmp_valid_s = (state_r == RUN);
         assign cmp_exp_s   = exp_s;
         assign cmp_mask_s  = mask_s;
         assign cmp_addr_s  = addr_r;
      end else begin : g_pipe
         logic            pv_r [EXP_LAT];
         logic [AW-1:0]   pa_r [EXP_LAT];
         logic [PA_W-1:0] pe_r [EXP_LAT];
         logic [PA_W-1:0] pm_r [EXP_LAT];

         // Delay line lining each issued vector up with the processor's response
         always_ff @(posedge clk or negedge CLB) begin
            if (!CLB) begin
               for (int i = 0; i < EXP_LAT; i++) begin
                  pv_r[i] <= 1'b0;
                  pa_r[i] <= {AW{1'b0}};
                  pe_r[i] <= {PA_W{1'b0}};
                  pm_r[i] <= {PA_W{1'b0}};
               end
            end else if (start && idle_s) begin
               for (int i = 0; i < EXP_LAT; i++) begin
                  pv_r[i] <= 1'b0;
               end
            end else begin
               pv_r[0] <= (state_r == RUN);
               pa_r[0] <= addr_r;
               pe_r[0] <= exp_s;
               pm_r[0] <= mask_s;
               for (int i = 1; i < EXP_LAT; i++) begin
                  pv_r[i] <= pv_r[i-1];
                  pa_r[i] <= pa_r[i-1];
                  pe_r[i] <= pe_r[i-1];
                  pm_r[i] <= pm_r[i-1];
               end
            end
         end

         assign cmp_valid_s = pv_r[EXP_LAT-1];
         assign cmp_exp_s   = pe_r[EXP_LAT-1];
         assign cmp_mask_s  = pm_r[EXP_LAT-1];
         assign cmp_addr_s  = pa_r[EXP_LAT-1];
      end
   endgenerate

   assign mism_s      = active_s && cmp_valid_s && (|((got_s ^ cmp_exp_s) & cmp_mask_s));
   assign run_end_s   = (state_r == RUN) && (addr_r == last_r);
   assign drain_end_s = (state_r == DRAIN) && (drain_r == DW'(EXP_LAT - 1));
   assign to_done_s   = (mism_s && stop_r) || drain_end_s || (run_end_s && (EXP_LAT == 0));

   // Run length clamp and saturating error increment
   always_comb begin
      if (num_vec > (AW+1)'(DEPTH)) begin
         nv_clamp_s = (AW+1)'(DEPTH);
      end else begin
         nv_clamp_s = num_vec;
      end
      if (mism_s && (err_count != {CNT_W{1'b1}})) begin
         err_next_s = err_count + CNT_W'(1);
      end else begin
         err_next_s = err_count;
      end
   end

   // Instruction only leaves the table while vectors are being issued
   always_comb begin
      if (state_r == RUN) begin
         inst = word_s[INST_LSB +: INST_W];
      end else begin
         inst = NOP_INST;
      end
   end

   // Run sequencing, error accounting and the registered status outputs
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         state_r        <= IDLE;
         addr_r         <= {AW{1'b0}};
         last_r         <= {AW{1'b0}};
         stop_r         <= 1'b0;
         drain_r        <= {DW{1'b0}};
         dut_clb        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= {CNT_W{1'b0}};
         first_err_addr <= {AW{1'b0}};
         first_err_got  <= {PA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  addr_r         <= {AW{1'b0}};
                  last_r         <= AW'(nv_clamp_s - (AW+1)'(1));
                  stop_r         <= stop_on_err;
                  drain_r        <= {DW{1'b0}};
                  err_count      <= {CNT_W{1'b0}};
                  first_err_addr <= {AW{1'b0}};
                  first_err_got  <= {PA_W{1'b0}};
                  if (nv_clamp_s == {(AW+1){1'b0}}) begin
                     state_r <= DONE;
                     dut_clb <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= 1'b1;
                  end else begin
                     state_r <= RUN;
                     dut_clb <= 1'b1;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                     pass    <= 1'b0;
                  end
               end
            end
            RUN, DRAIN: begin
               err_count <= err_next_s;
               // A zero count means no mismatch yet in this run, since it saturates
               if (mism_s && (err_count == {CNT_W{1'b0}})) begin
                  first_err_addr <= cmp_addr_s;
                  first_err_got  <= got_s;
               end
               if (to_done_s) begin
                  state_r <= DONE;
                  dut_clb <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_next_s == {CNT_W{1'b0}});
               end else if (run_end_s) begin
                  state_r <= DRAIN;
                  drain_r <= {DW{1'b0}};
               end else if (state_r == RUN) begin
                  addr_r <= addr_r + AW'(1);
               end else begin
                  drain_r <= drain_r + DW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable, parametrised self-checking vector sequencer for the 8-bit processor and its wider successors. Holds a loadable table of {instruction, expected PC, expected ACC} words. After `start` it releases the processor from reset, drives one instruction per clock, and compares the processor's {PC, ACC} against the table with a configurable pipeline latency. It reports pass/fail, an error count and first-failure capture, so processor regression runs on FPGA or emulator without a simulator-only bench.

## Interface
- INST_W, 8, instruction width
- PC_W, 8, processor PC width
- ACC_W, 8, accumulator width
- DEPTH, 24, vector table entries
- EXP_LAT, 0, edges between issuing vector k's instruction and comparing vector k's expected value
- CNT_W, 8, error counter width
- NOP_INST, 0, value driven on `inst` outside RUN
- Derived: AW = $clog2(DEPTH); VEC_W = INST_W+PC_W+ACC_W (+PC_W+ACC_W with mask, see Configuration)

- clk  in  1  single clock, all state on rising edge
- CLB  in  1  asynchronous, active-low reset
- ld_we  in  1  table write strobe; honoured only in IDLE/DONE
- ld_addr  in  AW  table write address
- ld_data  in  VEC_W  {inst, exp_pc, exp_acc[, mask]}, MSB first
- start  in  1  one-cycle pulse; honoured only in IDLE/DONE
- stop_on_err  in  1  sampled on the start edge
- num_vec  in  AW+1  vectors to run, sampled on start; values >DEPTH clamp to DEPTH
- dut_clb  out  1  active-low reset to the processor
- inst  out  INST_W  instruction to the processor
- pc  in  PC_W  processor PC
- acc  in  ACC_W  processor ACC
- busy  out  1  high in RUN/DRAIN
- done  out  1  high in DONE
- pass  out  1  valid when done: err_count==0
- err_count  out  CNT_W  saturating mismatch count
- first_err_addr  out  AW  vector index of first mismatch
- first_err_got  out  PC_W+ACC_W  {pc,acc} at first mismatch

## Operation
- States: IDLE → RUN → DRAIN → DONE; DONE → RUN on `start`.
- Reset (CLB low): state IDLE, dut_clb=0, inst=NOP_INST, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_got=0, address=0, latency pipe cleared. The table is not reset.
- `start` in IDLE/DONE:
  - clears counters and first-error capture
  - sets address=0, enters RUN, drives dut_clb=1 from the next cycle
  - num_vec==0 goes straight to DONE with pass=1.
- RUN: inst = table[address] (combinational read of the registered address). Each edge pushes {exp, mask, address, valid} into an EXP_LAT-deep pipe and increments address. After the edge that issues vector num_vec-1, the block enters DRAIN, or DONE if EXP_LAT==0.
- Compare: at each edge, a valid entry leaving the pipe (EXP_LAT==0: the current vector) is compared with the sampled {pc,acc}.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch of a run, first_err_addr and first_err_got are captured.
- stop_on_err=1: the first mismatch moves the block to DONE on that edge. Later pipe entries are discarded and not compared.
- DRAIN: inst=NOP_INST. Runs for EXP_LAT edges while compares continue, then DONE.
- DONE: dut_clb=0 (processor held in reset), inst=NOP_INST. Results hold until the next start or reset.
- ld_we and start in RUN/DRAIN are ignored. If ld_we and start occur on the same edge in IDLE/DONE, the write lands first; address 0 sees the new data.

## Timing
- Vector k's instruction is on `inst` during RUN cycle k.
- Vector k's compare happens at the edge ending cycle k+EXP_LAT.
- With EXP_LAT=0, expected[k] is the processor state before instruction k takes effect; expected[0] is the processor's reset state.
- Run length, start pulse to `done` high: 1 + num_vec + EXP_LAT cycles without an early stop.
- CLB asserted mid-run aborts immediately to the reset values; no partial results are retained.
- All outputs are registered except `inst` (table read of a registered address).

## Configuration
- VECTOR_CHECKER_MASK_EN defined:
  - each table word carries a PC_W+ACC_W care mask after exp_acc
  - a bit mismatch counts only where the mask bit is 1
  - VEC_W grows accordingly.
- Undefined: no mask field; every bit of {pc,acc} is compared.

## Structure
- vector_checker_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - field-offset functions for inst, exp and mask within a VEC_W word
- One sub-module: vector_checker_mem, a DEPTH×VEC_W table with one synchronous write port and one asynchronous read port, no reset.

## Test plan
- Load 3 vectors with a stub DUT that follows exp exactly; start, num_vec=3 → done after 4 cycles, pass=1, err_count=0, dut_clb high for exactly 3 cycles.
- Vector 1 exp={0x01,0x05}, DUT returns {0x01,0x07}, stop_on_err=0, num_vec=3 → err_count=1, first_err_addr=1, first_err_got=0x0107, done after all 3.
- Same stimulus with stop_on_err=1 → done at the vector-1 compare edge, err_count=1; the vector-2 compare does not occur.
- EXP_LAT=2, stub DUT delayed 2 cycles, num_vec=4 → pass=1, done 7 cycles after start, inst=NOP_INST during the 2 DRAIN cycles.
- CNT_W=2, every vector mismatching, num_vec=6 → err_count=3 (saturated), first_err_addr=0.
- CLB pulsed low mid-run at vector 2 → all outputs at reset values, state IDLE. A new start reruns from vector 0 with the table intact; with VECTOR_CHECKER_MASK_EN and mask=0x00FF, a PC-only mismatch gives pass=1.
